// File: rtl/periph_bus_master_pkg.sv
// Shared definitions for the peripheral bus master.
// Holds the pData field positions, command payload layout and FSM state encoding.
package periph_bus_master_pkg;

   localparam int unsigned BUS_W  = 23;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;

   // pData field positions
   localparam int unsigned WE_BIT  = 22;
   localparam int unsigned ADDR_HI = 21;
   localparam int unsigned ADDR_LO = 16;
   localparam int unsigned DIN_HI  = 15;
   localparam int unsigned DIN_LO  = 8;
   localparam int unsigned DOUT_HI = 7;
   localparam int unsigned DOUT_LO = 0;

   // FSM state encoding
   localparam int unsigned STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_SETUP   = 3'd1;
   localparam logic [STATE_W-1:0] ST_STROBE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_HOLD    = 3'd3;
   localparam logic [STATE_W-1:0] ST_WAIT    = 3'd4;
   localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd5;

   // Buffered command: {we, addr, wdata}
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/periph_cmd_fifo.sv
// Two-entry command FIFO with a valid/ready push side and a pop strobe.
// Ports: clk, rstN (async active-low), push_valid_i/push_data_i (push accepted
// when not full), pop_i (ignored when empty), pop_data_o (head entry),
// empty_o, full_o.
module periph_cmd_fifo
   import periph_bus_master_pkg::*;
(
   input  logic clk,
   input  logic rstN,
   input  logic push_valid_i,
   input  cmd_t push_data_i,
   input  logic pop_i,
   output cmd_t pop_data_o,
   output logic empty_o,
   output logic full_o
);

   cmd_t       mem_q [2];
   cmd_t       mem_d [2];
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       push;
   logic       pop;
   logic       wr_idx;

   assign full_o     = (count_q == 2'd2);
   assign empty_o    = (count_q == 2'd0);
   assign pop_data_o = mem_q[0];
   assign push       = push_valid_i && !full_o;
   assign pop        = pop_i && !empty_o;

   // Head always lives in slot 0; a pop shifts slot 1 down.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      wr_idx  = pop ? 1'b0 : count_q[0];
      if (pop) begin
         mem_d[0] = mem_q[1];
      end
      if (push) begin
         mem_d[wr_idx] = push_data_i;
      end
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mem_q   <= '{default: '0};
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus master: buffers commands in a 2-entry FIFO and runs each one
// as a strobed write or a timed read on the shared 23-bit pData bus.
// Ports: clk, rstN (async active-low); reqValid/reqReady/reqWe/reqAddr/reqWdata
// command input; rspValid/rspWrite/rspData one-cycle response; busy;
// pData inout bus ([22] we, [21:16] addr, [15:8] from peripheral, [7:0] to peripheral).
module periph_bus_master
   import periph_bus_master_pkg::*;
#(
   parameter int unsigned       READ_WAIT = 2,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = 6'd63
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWe,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqWdata,
   output logic              rspValid,
   output logic              rspWrite,
   output logic [DATA_W-1:0] rspData,
   output logic              busy,
   inout  wire  [BUS_W-1:0]  pData
);

   logic [STATE_W-1:0] state_q,     state_d;
   cmd_t               cmd_q,       cmd_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
   logic               bus_we_q,    bus_we_d;
   logic [ADDR_W-1:0]  bus_addr_q,  bus_addr_d;
   logic [DATA_W-1:0]  bus_dout_q,  bus_dout_d;

   cmd_t fifo_head;
   logic fifo_empty;
   logic fifo_full;
   logic fifo_pop;

   periph_cmd_fifo u_fifo (
      .clk          (clk),
      .rstN         (rstN),
      .push_valid_i (reqValid),
      .push_data_i  ({reqWe, reqAddr, reqWdata}),
      .pop_i        (fifo_pop),
      .pop_data_o   (fifo_head),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full)
   );

   assign reqReady = !fifo_full;
   assign busy     = !fifo_empty || (state_q != ST_IDLE);
   assign rspValid = rsp_valid_q;
   assign rspWrite = rsp_write_q;
   assign rspData  = rsp_data_q;

   // Master owns we/addr/dout; the peripheral data lane is never driven here.
   assign pData[WE_BIT]           = bus_we_q;
   assign pData[ADDR_HI:ADDR_LO]  = bus_addr_q;
   assign pData[DOUT_HI:DOUT_LO]  = bus_dout_q;
   assign pData[DIN_HI:DIN_LO]    = 8'bz;

   // Next-state, response and bus-drive logic
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_data_d  = rsp_data_q;
      fifo_pop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = CNT_W'(READ_WAIT - 1);
            state_d = cmd_q.we ? ST_STROBE : ST_WAIT;
         end
         ST_STROBE: begin
            // Response registers update so they are visible during HOLD.
            state_d     = ST_HOLD;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_data_d  = '0;
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            rsp_data_d  = pData[DIN_HI:DIN_LO];
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bus values are registered from the upcoming state.
      bus_we_d   = 1'b0;
      bus_addr_d = cmd_d.addr;
      bus_dout_d = cmd_d.we ? cmd_d.wdata : '0;
      if (state_d == ST_IDLE) begin
         bus_addr_d = IDLE_ADDR;
         bus_dout_d = '0;
      end else if (state_d == ST_STROBE) begin
         bus_we_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= IDLE_ADDR;
         bus_dout_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_data_q  <= rsp_data_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_dout_q  <= bus_dout_d;
      end
   end

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master: directed scenarios plus random
// traffic checked against a response queue and a bus-protocol monitor.
module tb_periph_bus_master;

   localparam logic [5:0] IDLE_ADDR = 6'd63;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   logic       reqValid = 1'b0;
   logic       reqWe = 1'b0;
   logic [5:0] reqAddr = 6'd0;
   logic [7:0] reqWdata = 8'd0;
   logic       reqReady, rspValid, rspWrite, busy;
   logic [7:0] rspData;
   wire [22:0] pData;

   logic       rv1 = 1'b0, rv15 = 1'b0;
   logic       rr1, rr15, rsv1, rsv15, rsw1, rsw15, b1, b15;
   logic [7:0] rsd1, rsd15;
   wire [22:0] pd1, pd15;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Responder: registers 13..19 answer with a fixed value, others float.
   function automatic logic [7:0] resp_val(input logic [5:0] a);
      if (a == 6'd14) return 8'h3C;
      return 8'(({2'b00, a} * 8'd7) + 8'd1);
   endfunction
   function automatic bit mapped(input logic [5:0] a);
      return (a >= 6'd13) && (a <= 6'd19);
   endfunction

   assign pData[15:8] = mapped(pData[21:16]) ? resp_val(pData[21:16]) : 8'bz;
   assign pd1[15:8]   = mapped(pd1[21:16])   ? resp_val(pd1[21:16])   : 8'bz;
   assign pd15[15:8]  = mapped(pd15[21:16])  ? resp_val(pd15[21:16])  : 8'bz;

   periph_bus_master dut (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady),
      .reqWe(reqWe), .reqAddr(reqAddr), .reqWdata(reqWdata),
      .rspValid(rspValid), .rspWrite(rspWrite), .rspData(rspData),
      .busy(busy), .pData(pData)
   );

   periph_bus_master #(.READ_WAIT(1)) dut_rw1 (
      .clk(clk), .rstN(rstN), .reqValid(rv1), .reqReady(rr1),
      .reqWe(reqWe), .reqAddr(reqAddr), .reqWdata(reqWdata),
      .rspValid(rsv1), .rspWrite(rsw1), .rspData(rsd1),
      .busy(b1), .pData(pd1)
   );

   periph_bus_master #(.READ_WAIT(15)) dut_rw15 (
      .clk(clk), .rstN(rstN), .reqValid(rv15), .reqReady(rr15),
      .reqWe(reqWe), .reqAddr(reqAddr), .reqWdata(reqWdata),
      .rspValid(rsv15), .rspWrite(rsw15), .rspData(rsd15),
      .busy(b15), .pData(pd15)
   );

   // Reference model: every accepted command yields one response, in order.
   typedef struct {
      logic       we;
      logic [7:0] data;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   logic       prev_we, prev_rv;
   logic [5:0] prev_addr;

   // Monitor on the main bus, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rstN) begin
         prev_we   = 1'b0;
         prev_rv   = 1'b0;
         prev_addr = IDLE_ADDR;
      end else begin
         if (rspValid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: got we=%0b data=%h, want no response", rspWrite, rspData);
            end else begin
               e = exp_q.pop_front();
               if (rspWrite !== e.we || rspData !== e.data) begin
                  n_fail++;
                  $display("FAIL rsp_order: got we=%0b data=%h, want we=%0b data=%h",
                           rspWrite, rspData, e.we, e.data);
               end
            end
         end
         if (reqValid && reqReady) begin
            exp_q.push_back('{reqWe, reqWe ? 8'h00 : resp_val(reqAddr)});
         end
         n_checks += 5;
         if ($isunknown({pData[22:16], pData[7:0]})) begin
            n_fail++;
            $display("FAIL bus_x: got pData=%h, want no X/Z on master fields", pData);
         end
         if (prev_we && pData[22]) begin
            n_fail++;
            $display("FAIL we_twice: got we=1 two cycles, want single-cycle strobe");
         end
         if (prev_rv && rspValid) begin
            n_fail++;
            $display("FAIL rsp_twice: got rspValid two cycles, want one");
         end
         if (pData[21:16] != IDLE_ADDR && prev_addr != IDLE_ADDR && pData[21:16] != prev_addr) begin
            n_fail++;
            $display("FAIL idle_gap: got addr %0d -> %0d, want IDLE_ADDR between", prev_addr, pData[21:16]);
         end
         if (mapped(pData[21:16]) && pData[15:8] !== resp_val(pData[21:16])) begin
            n_fail++;
            $display("FAIL contention: got din=%h, want %h", pData[15:8], resp_val(pData[21:16]));
         end
         prev_we   = pData[22];
         prev_rv   = rspValid;
         prev_addr = pData[21:16];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and return just after the edge that accepts it.
   task automatic send(input logic we, input logic [5:0] a, input logic [7:0] d);
      int waited = 0;
      reqWe = we; reqAddr = a; reqWdata = d; reqValid = 1'b1;
      while (!reqReady && waited < 50) begin
         step();
         waited++;
      end
      n_checks++;
      if (!reqReady) begin
         n_fail++;
         $display("FAIL send_timeout: got reqReady=0 for %0d cycles, want 1", waited);
      end
      step();
      reqValid = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      step(); step();
      n_checks++;
      if ({rspValid, rspWrite, rspData, busy} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_rsp: got v=%0b w=%0b d=%h busy=%0b, want all 0", rspValid, rspWrite, rspData, busy);
      end
      n_checks++;
      if ({pData[22], pData[21:16], pData[7:0]} !== {1'b0, IDLE_ADDR, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_bus: got we=%0b addr=%0d dout=%h, want 0/63/00", pData[22], pData[21:16], pData[7:0]);
      end
      #2 rstN = 1'b1;
      step();
      n_checks++;
      if (reqReady !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%0b busy=%0b, want 1/0", reqReady, busy);
      end
   endtask

   task automatic test_write();
      send(1'b1, 6'd13, 8'hA5);
      n_checks++;
      if (pData[21:16] !== IDLE_ADDR || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_pop: got addr=%0d busy=%0b, want 63/1", pData[21:16], busy);
      end
      step();
      n_checks++;
      if ({pData[22], pData[21:16], pData[7:0], rspValid} !== {1'b0, 6'd13, 8'hA5, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_setup: got we=%0b addr=%0d dout=%h rv=%0b, want 0/13/A5/0",
                  pData[22], pData[21:16], pData[7:0], rspValid);
      end
      step();
      n_checks++;
      if ({pData[22], pData[21:16], pData[7:0]} !== {1'b1, 6'd13, 8'hA5}) begin
         n_fail++;
         $display("FAIL wr_strobe: got we=%0b addr=%0d dout=%h, want 1/13/A5", pData[22], pData[21:16], pData[7:0]);
      end
      step();
      n_checks++;
      if ({pData[22], pData[21:16], rspValid, rspWrite, rspData} !== {1'b0, 6'd13, 1'b1, 1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL wr_hold: got we=%0b addr=%0d rv=%0b rw=%0b rd=%h, want 0/13/1/1/00",
                  pData[22], pData[21:16], rspValid, rspWrite, rspData);
      end
      step();
      n_checks++;
      if ({pData[22], pData[21:16], pData[7:0], rspValid} !== {1'b0, IDLE_ADDR, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_idle: got we=%0b addr=%0d dout=%h rv=%0b, want 0/63/00/0",
                  pData[22], pData[21:16], pData[7:0], rspValid);
      end
   endtask

   task automatic test_read();
      int lat = 0;
      send(1'b0, 6'd14, 8'h5A);
      do begin
         step();
         lat++;
         if (lat == 1 || lat == 4) begin
            n_checks++;
            if ({pData[22], pData[21:16], pData[7:0]} !== {1'b0, 6'd14, 8'h00}) begin
               n_fail++;
               $display("FAIL rd_addr_hold: cycle %0d got we=%0b addr=%0d dout=%h, want 0/14/00",
                        lat, pData[22], pData[21:16], pData[7:0]);
            end
         end
      end while (!rspValid && lat < 20);
      n_checks++;
      if (lat != 5 || rspWrite !== 1'b0 || rspData !== 8'h3C) begin
         n_fail++;
         $display("FAIL rd_rsp: got lat=%0d rw=%0b rd=%h, want 5/0/3C", lat, rspWrite, rspData);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] addrs[4];
      logic [5:0] addr_log[int];
      int         rsp_cyc[$];
      int         t0 = 0;
      logic [5:0] want;
      addrs = '{6'd15, 6'd16, 6'd17, 6'd18};
      fork
         begin
            send(1'b1, addrs[0], 8'($urandom));
            t0 = cyc;
            send(1'b1, addrs[1], 8'($urandom));
            send(1'b1, addrs[2], 8'($urandom));
            n_checks++;
            if (reqReady !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_full: got reqReady=%0b, want 0", reqReady);
            end
            send(1'b1, addrs[3], 8'($urandom));
         end
         begin
            for (int k = 0; k < 20; k++) begin
               step();
               addr_log[cyc] = pData[21:16];
               if (rspValid) rsp_cyc.push_back(cyc);
            end
         end
      join
      n_checks++;
      if (rsp_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d responses, want 4", rsp_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_cyc[i] - t0 != 3 + 4 * i) begin
               n_fail++;
               $display("FAIL b2b_latency: rsp %0d got cycle %0d, want %0d", i, rsp_cyc[i] - t0, 3 + 4 * i);
            end
         end
      end
      for (int k = 1; k < 16; k++) begin
         want = (k % 4 == 0) ? IDLE_ADDR : addrs[k / 4];
         n_checks++;
         if (!addr_log.exists(t0 + k) || addr_log[t0 + k] !== want) begin
            n_fail++;
            $display("FAIL b2b_addr: cycle %0d got %0d, want %0d", k,
                     addr_log.exists(t0 + k) ? addr_log[t0 + k] : 6'd0, want);
         end
      end
   endtask

   task automatic test_reset_strobe();
      send(1'b1, 6'd20, 8'h77);
      step(); step();
      n_checks++;
      if (pData[22] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_strobe: got we=%0b, want 1", pData[22]);
      end
      #2 rstN = 1'b0;
      #1;
      n_checks++;
      if ({pData[22], pData[21:16], pData[7:0], busy, rspValid} !== {1'b0, IDLE_ADDR, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_async: got we=%0b addr=%0d dout=%h busy=%0b rv=%0b, want 0/63/00/0/0",
                  pData[22], pData[21:16], pData[7:0], busy, rspValid);
      end
      step(); step();
      n_checks++;
      if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_hold: got rv=%0b ready=%0b, want 0/1", rspValid, reqReady);
      end
      exp_q.delete();
      #2 rstN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (rspValid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: got rv=%0b busy=%0b, want 0/0", rspValid, busy);
         end
      end
   endtask

   task automatic test_random();
      int   waited = 0;
      logic we;
      for (int i = 0; i < 60; i++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
         we = 1'($urandom_range(0, 1));
         send(we, we ? 6'($urandom_range(0, 62)) : 6'($urandom_range(13, 19)), 8'($urandom));
      end
      while ((exp_q.size() != 0 || busy) && waited < 300) begin
         step();
         waited++;
      end
      n_checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_drain: got %0d pending busy=%0b, want 0/0", exp_q.size(), busy);
      end
   endtask

   task automatic test_read_wait();
      int t0;
      int lat1 = -1, lat15 = -1;
      logic [7:0] d1 = 8'h00, d15 = 8'h00;
      reqWe = 1'b0; reqAddr = 6'd16; rv1 = 1'b1; rv15 = 1'b1;
      step();
      rv1 = 1'b0; rv15 = 1'b0;
      t0 = cyc;
      for (int k = 0; k < 30; k++) begin
         step();
         if (rsv1 && lat1 < 0)   begin lat1 = cyc - t0;  d1 = rsd1;  end
         if (rsv15 && lat15 < 0) begin lat15 = cyc - t0; d15 = rsd15; end
      end
      n_checks++;
      if (lat1 != 4 || d1 !== resp_val(6'd16)) begin
         n_fail++;
         $display("FAIL rw1: got lat=%0d data=%h, want 4/%h", lat1, d1, resp_val(6'd16));
      end
      n_checks++;
      if (lat15 != 18 || d15 !== resp_val(6'd16)) begin
         n_fail++;
         $display("FAIL rw15: got lat=%0d data=%h, want 18/%h", lat15, d15, resp_val(6'd16));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_strobe();
      test_random();
      test_read_wait();
      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
